// File: rtl/mw_seq_adder_pipe.sv
// Multi-word sequential adder/subtractor: LS-word-first beats, carry chained across beats,
// two-stage valid/ready pipeline. Define MW_ADDER_SUB_EN to honour s_sub (else pure adder).
module mw_seq_adder_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic             s_first,
  input  logic             s_last,
  input  logic             s_sub,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_sum,
  output logic             m_last,
  output logic             m_carry,
  output logic             m_ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_first_q, s1_last_q, s1_sub_q;

  logic             m_valid_q;
  logic [WIDTH-1:0] m_sum_q;
  logic             m_last_q, m_carry_q, m_ovf_q;

  logic             carry_q, sub_q;

  logic             adv2, accept, sub_in, sub_eff, cin, cout, ovf_d;
  logic [WIDTH-1:0] b_eff, sum_d;

`ifdef MW_ADDER_SUB_EN
  assign sub_in = s_sub;
`else
  // Subtraction compiled out; the port stays so the interface is build-independent.
  logic unused_sub;
  assign unused_sub = s_sub;
  assign sub_in     = 1'b0;
`endif

  always_comb begin
    adv2    = s1_valid_q & (~m_valid_q | m_ready);
    s_ready = ~s1_valid_q | adv2;
    accept  = s_valid & s_ready;

    // The operation is latched on the first beat; later beats follow the chain's mode.
    sub_eff = s1_first_q ? s1_sub_q : sub_q;
    b_eff   = sub_eff ? ~s1_b_q : s1_b_q;
    cin     = s1_first_q ? sub_eff : carry_q;
    {cout, sum_d} = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    ovf_d   = s1_last_q & (s1_a_q[Msb] == b_eff[Msb]) & (sum_d[Msb] != s1_a_q[Msb]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= s_a;
      s1_b_q     <= s_b;
      s1_first_q <= s_first;
      s1_last_q  <= s_last;
      s1_sub_q   <= sub_in;
    end else if (adv2) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_last_q  <= 1'b0;
      m_carry_q <= 1'b0;
      m_ovf_q   <= 1'b0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
    end else if (adv2) begin
      m_valid_q <= 1'b1;
      m_sum_q   <= sum_d;
      m_last_q  <= s1_last_q;
      m_carry_q <= cout;
      m_ovf_q   <= ovf_d;
      carry_q   <= s1_last_q ? 1'b0 : cout;
      if (s1_last_q) begin
        sub_q <= 1'b0;
      end else if (s1_first_q) begin
        sub_q <= sub_eff;
      end
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_sum   = m_sum_q;
  assign m_last  = m_last_q;
  assign m_carry = m_carry_q;
  assign m_ovf   = m_ovf_q;

endmodule
